// File: rtl/sqrt_share_arbiter.sv
// Round-robin arbiter sharing one iterative fixed-point sqrt unit.
// Define SQRT_ARB_PERF_EN to add the perf_ops / perf_stall counters.
module sqrt_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int SQRT_CYCLES = 24,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic                     sqrt_go,
  output logic [WIDTH-1:0]         sqrt_in,
  input  logic [WIDTH-1:0]         sqrt_out,
  input  logic                     sqrt_done,
  output logic                     busy
`ifdef SQRT_ARB_PERF_EN
  ,
  output logic [31:0]              perf_ops,
  output logic [31:0]              perf_stall
`endif
);

  localparam int FLUSH_N = SQRT_CYCLES + 2;
  localparam int CNT_W   = $clog2(FLUSH_N);

  typedef enum logic [2:0] {
    FLUSH, IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  flush_cnt;
  logic [ID_W-1:0]   rr, id, grant;
  logic              grant_ok;
  logic [WIDTH-1:0]  opnd;
  logic              accept, resp_fire, flush_end;

  assign flush_end = flush_cnt == CNT_W'(FLUSH_N - 1);
  assign sqrt_in   = opnd;
  assign busy      = state != IDLE;

  // first valid requester at or above rr, wrapping
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [ID_W:0] idx;
      idx = {1'b0, rr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ))
        idx = idx - (ID_W+1)'(NUM_REQ);
      if (!grant_ok && req_valid[idx[ID_W-1:0]]) begin
        grant    = idx[ID_W-1:0];
        grant_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    resp_valid = '0;
    sqrt_go    = 1'b0;
    accept     = 1'b0;
    resp_fire  = 1'b0;
    unique case (state)
      FLUSH: if (flush_end) state_nx = IDLE;
      IDLE: begin
        if (grant_ok) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nx         = ISSUE;
        end
      end
      ISSUE: begin
        sqrt_go  = 1'b1;
        state_nx = WAIT;
      end
      WAIT: if (sqrt_done) state_nx = RESP;
      RESP: begin
        resp_valid[id] = 1'b1;
        if (resp_ready[id]) begin
          resp_fire = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = FLUSH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FLUSH;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= '0;
      rr        <= '0;
      id        <= '0;
      opnd      <= '0;
      resp_data <= '0;
    end else begin
      // the unit has no reset: outlast any op it may still be running
      if (state == FLUSH && !flush_end)
        flush_cnt <= flush_cnt + 1'b1;
      if (accept) begin
        id   <= grant;
        opnd <= req_data[grant*WIDTH +: WIDTH];
      end
      if (state == WAIT && sqrt_done)
        resp_data <= sqrt_out;
      if (resp_fire)
        rr <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    end
  end

`ifdef SQRT_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else if (state != FLUSH) begin
      if (resp_fire)
        perf_ops <= perf_ops + 32'd1;
      if (|req_valid && state != IDLE)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  a_go_only_issue: assert property (
    @(posedge clk) disable iff (reset)
    sqrt_go |-> state == ISSUE);

  a_onehot: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0(req_ready) && $onehot0(resp_valid));

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Bench for sqrt_share_arbiter with a behavioural sqrt unit model.
module tb_sqrt_share_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int WIDTH       = 32;
  localparam int SQRT_CYCLES = 24;
  localparam int FRAC        = 16;
  localparam int FLUSH_N     = SQRT_CYCLES + 2;
  localparam int LAT         = SQRT_CYCLES + 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_data;
  logic [NUM_REQ-1:0]       resp_ready;
  logic                     sqrt_go;
  logic [WIDTH-1:0]         sqrt_in;
  logic [WIDTH-1:0]         sqrt_out;
  logic                     sqrt_done;
  logic                     busy;
`ifdef SQRT_ARB_PERF_EN
  logic [31:0]              perf_ops;
  logic [31:0]              perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_rr   = 0;

  logic             extra_done = 1'b0;
  logic             model_done = 1'b0;
  logic [WIDTH-1:0] model_out  = '0;
  logic [WIDTH-1:0] model_opnd = '0;
  bit               model_run  = 1'b0;
  int               model_left = 0;

  always #5 clk = ~clk;

  sqrt_share_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .SQRT_CYCLES(SQRT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready),
    .sqrt_go(sqrt_go), .sqrt_in(sqrt_in),
    .sqrt_out(sqrt_out), .sqrt_done(sqrt_done),
    .busy(busy)
`ifdef SQRT_ARB_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  // Q16.16 square root, floor of sqrt(x * 2^16)
  function automatic logic [WIDTH-1:0] ref_sqrt(input logic [WIDTH-1:0] x);
    longint unsigned v, lo, hi, mid;
    v  = longint'(x) << FRAC;
    lo = 0;
    hi = (64'd1 << 24) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return WIDTH'(lo);
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] m, input int from);
    for (int k = 0; k < NUM_REQ; k++)
      if (m[(from + k) % NUM_REQ]) return (from + k) % NUM_REQ;
    return -1;
  endfunction

  // sqrt unit: no reset, done pulses SQRT_CYCLES cycles after go
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (sqrt_go) begin
      model_run  <= 1'b1;
      model_left <= SQRT_CYCLES - 1;
      model_opnd <= sqrt_in;
    end else if (model_run) begin
      if (model_left == 1) begin
        model_done <= 1'b1;
        model_out  <= ref_sqrt(model_opnd);
        model_run  <= 1'b0;
      end else begin
        model_left <= model_left - 1;
      end
    end
  end

  assign sqrt_done = model_done | extra_done;
  assign sqrt_out  = extra_done ? 32'hDEADBEEF : model_out;

  task automatic run_op(
    input  logic [NUM_REQ-1:0]       mask,
    input  logic [NUM_REQ*WIDTH-1:0] data,
    output logic [NUM_REQ-1:0]       rdy,
    output logic [NUM_REQ-1:0]       rv,
    output logic [WIDTH-1:0]         rd,
    output int                       lat);
    req_data  = data;
    req_valid = mask;
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    #1;
    while (resp_valid == '0 && lat < 300) begin
      @(negedge clk);
      #1 lat++;
    end
    rv = resp_valid;
    rd = resp_data;
    resp_ready = rv;
    @(negedge clk);
    resp_ready = '0;
  endtask

  task automatic test_reset();
    int bad;
    req_valid  = '1;
    req_data   = '0;
    resp_ready = '0;
    reset      = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, sqrt_go, busy} !== {8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_ctl: rdy=%b rv=%b go=%b busy=%b exp 0000 0000 0 1",
        req_ready, resp_valid, sqrt_go, busy);
    end
    n_checks++;
    if (resp_data !== '0 || sqrt_in !== '0) begin
      n_fail++;
      $display("FAIL reset_data: resp_data=%h sqrt_in=%h exp 0 0",
        resp_data, sqrt_in);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < FLUSH_N; c++) begin
      #1;
      n_checks++;
      if (busy !== 1'b1 || req_ready !== '0) begin
        n_fail++;
        $display("FAIL flush_hold c=%0d: busy=%b rdy=%b exp 1 0000",
          c, busy, req_ready);
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL flush_exit: busy=%b rdy=%b exp 0 0001", busy, req_ready);
    end
    req_valid = '0;
    exp_rr = 0;
    @(negedge clk);
  endtask

  task automatic test_single_op();
    logic [WIDTH-1:0] ops  [3];
    logic [WIDTH-1:0] expd [3];
    logic [NUM_REQ*WIDTH-1:0] data;
    logic [NUM_REQ-1:0] rdy, rv;
    logic [WIDTH-1:0] rd;
    int lat;
    ops  = '{32'h00020000, 32'h00090000, 32'h0};
    expd = '{32'h00016A09, 32'h00030000, 32'h0};
    for (int i = 0; i < 3; i++) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      data[2*WIDTH +: WIDTH] = ops[i];
      run_op(4'b0100, data, rdy, rv, rd, lat);
      n_checks++;
      if (rdy !== 4'b0100 || rv !== 4'b0100) begin
        n_fail++;
        $display("FAIL single_id %0d: rdy=%b rv=%b exp 0100", i, rdy, rv);
      end
      n_checks++;
      if (rd !== expd[i]) begin
        n_fail++;
        $display("FAIL single_data %0d: got %h exp %h", i, rd, expd[i]);
      end
      n_checks++;
      if (lat != LAT) begin
        n_fail++;
        $display("FAIL single_lat %0d: got %0d exp %0d", i, lat, LAT);
      end
      exp_rr = 3;
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ*WIDTH-1:0] data;
    logic [NUM_REQ-1:0] mask, rdy, rv, want;
    logic [WIDTH-1:0] rd, wd;
    int lat, g;
    for (int i = 0; i < 16; i++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int r = 0; r < NUM_REQ; r++)
        data[r*WIDTH +: WIDTH] = (i % 4 == 0) ? WIDTH'($urandom_range(0, 255))
                                              : $urandom;
      g    = pick(mask, exp_rr);
      want = NUM_REQ'(1) << g;
      wd   = ref_sqrt(data[g*WIDTH +: WIDTH]);
      run_op(mask, data, rdy, rv, rd, lat);
      n_checks++;
      if (rdy !== want || rv !== want) begin
        n_fail++;
        $display("FAIL rand_grant %0d: mask=%b rdy=%b rv=%b exp %b",
          i, mask, rdy, rv, want);
      end
      n_checks++;
      if (rd !== wd || lat != LAT) begin
        n_fail++;
        $display("FAIL rand_data %0d: got %h lat %0d exp %h lat %0d",
          i, rd, lat, wd, LAT);
      end
      exp_rr = (g + 1) % NUM_REQ;
    end
  endtask

  task automatic test_fairness(input int nops, output int stall);
    logic [WIDTH-1:0] ops [NUM_REQ];
    logic [NUM_REQ-1:0] want;
    int grants, resps, exp_g, exp_r, cyc;
    for (int r = 0; r < NUM_REQ; r++) begin
      ops[r] = $urandom;
      req_data[r*WIDTH +: WIDTH] = ops[r];
    end
    stall  = 0;
    grants = 0;
    resps  = 0;
    exp_g  = exp_rr;
    exp_r  = exp_rr;
    cyc    = 0;
    req_valid  = '1;
    resp_ready = '1;
    while (resps < nops && cyc < 4000) begin
      #1;
      if (|req_valid && busy) stall++;
      if (req_ready != '0) begin
        want = NUM_REQ'(1) << exp_g;
        n_checks++;
        if (req_ready !== want) begin
          n_fail++;
          $display("FAIL fair_grant %0d: got %b exp %b", grants, req_ready, want);
        end
        exp_g = (exp_g + 1) % NUM_REQ;
        grants++;
      end
      if (resp_valid != '0) begin
        want = NUM_REQ'(1) << exp_r;
        n_checks++;
        if (resp_valid !== want || resp_data !== ref_sqrt(ops[exp_r])) begin
          n_fail++;
          $display("FAIL fair_resp %0d: rv=%b data=%h exp %b %h", resps,
            resp_valid, resp_data, want, ref_sqrt(ops[exp_r]));
        end
        exp_r = (exp_r + 1) % NUM_REQ;
        resps++;
      end
      @(negedge clk);
      cyc++;
      if (grants >= nops) req_valid = '0;
    end
    n_checks++;
    if (resps != nops || grants != nops) begin
      n_fail++;
      $display("FAIL fair_count: grants=%0d resps=%0d exp %0d", grants, resps, nops);
    end
    req_valid  = '0;
    resp_ready = '0;
    exp_rr = exp_r;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [NUM_REQ-1:0] rv0;
    logic [WIDTH-1:0] rd0, opnd;
    int cyc;
    opnd = $urandom;
    req_data[1*WIDTH +: WIDTH] = opnd;
    req_valid = 4'b0010;
    #1;
    @(negedge clk);
    req_valid = '0;
    cyc = 0;
    #1;
    while (resp_valid == '0 && cyc < 300) begin
      @(negedge clk);
      #1 cyc++;
    end
    rv0 = resp_valid;
    rd0 = resp_data;
    n_checks++;
    if (rv0 !== 4'b0010 || rd0 !== ref_sqrt(opnd)) begin
      n_fail++;
      $display("FAIL bp_resp: rv=%b data=%h exp 0010 %h", rv0, rd0, ref_sqrt(opnd));
    end
    req_valid  = 4'b1101;
    resp_ready = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      extra_done = (c == 3);
      #1;
      n_checks++;
      if (resp_valid !== rv0 || resp_data !== rd0 ||
          req_ready !== '0 || sqrt_go !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d: rv=%b data=%h rdy=%b go=%b exp %b %h 0000 0",
          c, resp_valid, resp_data, req_ready, sqrt_go, rv0, rd0);
      end
    end
    @(negedge clk);
    extra_done = 1'b0;
    req_valid  = '0;
    resp_ready = 4'b0010;
    @(negedge clk);
    resp_ready = '0;
    extra_done = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || resp_valid !== '0) begin
      n_fail++;
      $display("FAIL bp_release: busy=%b rv=%b exp 0 0000", busy, resp_valid);
    end
    @(negedge clk);
    extra_done = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || resp_data !== rd0) begin
      n_fail++;
      $display("FAIL idle_done: busy=%b data=%h exp 0 %h", busy, resp_data, rd0);
    end
    exp_rr = 2;
    @(negedge clk);
  endtask

  task automatic test_midop_reset();
    logic [NUM_REQ*WIDTH-1:0] data;
    logic [NUM_REQ-1:0] rdy, rv;
    logic [WIDTH-1:0] rd;
    int lat;
    bit seen;
    req_data[3*WIDTH +: WIDTH] = $urandom;
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    repeat (8) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || resp_valid !== '0) begin
      n_fail++;
      $display("FAIL mid_wait: busy=%b rv=%b exp 1 0000", busy, resp_valid);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, sqrt_go, busy} !== {8'h00, 1'b0, 1'b1} ||
        resp_data !== '0 || sqrt_in !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rdy=%b rv=%b go=%b busy=%b data=%h in=%h exp 0 0 0 1 0 0",
        req_ready, resp_valid, sqrt_go, busy, resp_data, sqrt_in);
    end
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < FLUSH_N; c++) begin
      extra_done = (c == FLUSH_N - 2);
      #1;
      if (model_done) seen = 1'b1;
      n_checks++;
      if (busy !== 1'b1 || resp_valid !== '0 || resp_data !== '0 ||
          sqrt_go !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_flush c=%0d: busy=%b rv=%b data=%h go=%b exp 1 0 0 0",
          c, busy, resp_valid, resp_data, sqrt_go);
      end
      @(negedge clk);
    end
    extra_done = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || seen !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_flush_end: busy=%b stale_done_seen=%b exp 0 1", busy, seen);
    end
    exp_rr = 0;
    data = '0;
    data[3*WIDTH +: WIDTH] = 32'h00040000;
    run_op(4'b1000, data, rdy, rv, rd, lat);
    n_checks++;
    if (rdy !== 4'b1000 || rv !== 4'b1000 || rd !== 32'h00020000 || lat != LAT) begin
      n_fail++;
      $display("FAIL mid_next_op: rdy=%b rv=%b data=%h lat=%0d exp 1000 1000 00020000 %0d",
        rdy, rv, rd, lat, LAT);
    end
    exp_rr = 0;
  endtask

`ifdef SQRT_ARB_PERF_EN
  task automatic test_perf();
    int stall;
    test_reset();
    n_checks++;
    if (perf_ops !== 32'd0 || perf_stall !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_frozen: ops=%0d stall=%0d exp 0 0", perf_ops, perf_stall);
    end
    test_fairness(4, stall);
    n_checks++;
    if (perf_ops !== 32'd4 || perf_stall !== 32'(stall)) begin
      n_fail++;
      $display("FAIL perf_count: ops=%0d stall=%0d exp 4 %0d",
        perf_ops, perf_stall, stall);
    end
  endtask
`endif

  initial begin
    int stall;
    test_reset();
    test_single_op();
    test_random();
    test_fairness(8, stall);
    test_backpressure();
    test_midop_reset();
    test_random();
`ifdef SQRT_ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sqrt_share_arbiter.md
Name: sqrt_share_arbiter

Overview:
Shares one iterative fixed-point square-root unit (go/done handshake, no reset of its own) among NUM_REQ requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin and only one operation is in flight at a time.
- Sits between accelerator lanes and the single sqrt instance, and sequences go and result capture.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 32, operand/result width; matches the sqrt unit
SQRT_CYCLES, 24, cycles from go to done for the attached unit, i.e. (WIDTH+FRAC_WIDTH)/2; sizes the post-reset flush
ID_W, $clog2(NUM_REQ), requester index width (derived)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_data  in  NUM_REQ*WIDTH  packed operands; requester i at [i*WIDTH +: WIDTH]
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
resp_valid  out  NUM_REQ  per-requester result valid, one-hot or zero
resp_data  out  WIDTH  result, shared by all requesters, meaningful where resp_valid is set
resp_ready  in  NUM_REQ  per-requester result accept
sqrt_go  out  1  start pulse to the sqrt unit
sqrt_in  out  WIDTH  operand to the sqrt unit
sqrt_out  in  WIDTH  sqrt unit result
sqrt_done  in  1  sqrt unit completion pulse
busy  out  1  high in any state except IDLE

Behaviour:
Interface and reset:
- One clock domain (clk); reset is asynchronous and active-high.
- On reset: state=FLUSH, flush counter=0, rr pointer=0, req_ready=0, resp_valid=0, resp_data=0, sqrt_go=0, sqrt_in=0, busy=1.

States:
- FLUSH: the sqrt unit has no reset and may still be running a stale op. Count SQRT_CYCLES+2 cycles, ignore sqrt_done, then go to IDLE. This applies after every reset, including reset mid-operation.
- IDLE: grant = first set req_valid bit searching from rr pointer upward, wrapping at NUM_REQ.
  - req_ready[grant]=1 combinationally, only in IDLE with some req_valid set.
  - On the handshake (valid&ready), latch operand and id, then go to ISSUE.
  - req_ready must never assert for a requester whose req_valid is low.
- ISSUE: sqrt_go=1 for exactly one cycle, with sqrt_in=latched operand; next state is WAIT.
  - sqrt_in holds the latched operand from ISSUE through WAIT.
- WAIT: on sqrt_done=1, register sqrt_out into resp_data and go to RESP. There is no timeout.
- RESP: resp_valid[id]=1 and resp_data stable.
  - On resp_ready[id], go to IDLE and set rr pointer = id+1, wrapping to 0 at NUM_REQ.
  - resp_ready bits of other requesters are ignored.

Timing and events:
- Latency: request accepted at cycle T; sqrt_go at T+1; resp_valid at the cycle after sqrt_done is sampled, i.e. T+2+SQRT_CYCLES nominal.
- sqrt_done outside WAIT is ignored.
- A requester that drops req_valid before its grant simply loses the arbitration; this is legal.
- Back-to-back operation: a new request can be accepted in the cycle immediately after a response handshake, since IDLE is re-entered.

Invariants (checked by assertions):
- sqrt_go is never asserted in FLUSH, IDLE, WAIT or RESP.
- At most one req_ready bit and at most one resp_valid bit are high.

Optional Feature:
SQRT_ARB_PERF_EN
- Defined: adds outputs perf_ops (32 bits, count of completed response handshakes) and perf_stall (32 bits, cycles with any req_valid set while state≠IDLE).
  - Both reset to 0 and wrap at 2^32.
  - Both are frozen during FLUSH.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset then idle: confirm busy=1 and req_ready=0 for SQRT_CYCLES+2 cycles even with req_valid=4'b1111; after that, busy=0 and req_ready=4'b0001.
2. Single op (WIDTH=32, FRAC_WIDTH=16): requester 2 sends 0x00020000 (2.0) -> resp_valid=4'b0100 with resp_data=0x00016A09. Then 0x00090000 -> 0x00030000, and 0x0 -> 0x0.
3. Fairness: hold req_valid=4'b1111 with resp_ready always high -> grant order 0,1,2,3,0 with no requester granted twice consecutively.
4. Response backpressure: keep resp_ready low for 10 cycles in RESP -> resp_valid and resp_data stay stable, req_ready=0, no sqrt_go. Releasing resp_ready returns to IDLE.
5. Mid-op reset: assert reset during WAIT -> outputs return to reset values, FLUSH runs to completion, and a stale sqrt_done is ignored. The next op (0x00040000) returns 0x00020000.
6. With SQRT_ARB_PERF_EN: after 4 ops under contention, perf_ops=4 and perf_stall equals the bench-counted stall cycles.
